// File: rtl/seg_pkg.sv
// +-----------------------------------------------------------------------------+
// | seg_pkg : shared types, constants and helpers for the 7-segment scanner     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } seg_state_e;

  // Wide enough for the largest supported display; users slice to NUM_DIGITS.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_tick_counter.sv
// +-----------------------------------------------------------------------------+
// | seg_tick_counter : loadable down-counter with a zero flag, saturates at 0   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seg_tick_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// +-----------------------------------------------------------------------------+
// | seg_scan_ctrl : double-buffered multiplexed scan controller, N-digit 7-seg  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ack,
  output logic [3:0]              digit_nibble,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int CNT_W = clog2((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC);
  localparam logic [NUM_DIGITS-1:0] C_ANODE_OFF = ANODE_OFF[NUM_DIGITS-1:0];
  localparam logic [CNT_W-1:0] C_SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  seg_state_e              state_q,     state_d;
  logic [IDX_W-1:0]        idx_q,       idx_d;
  logic [NUM_DIGITS-1:0]   anode_q,     anode_d;
  logic [3:0]              nibble_q,    nibble_d;
  logic                    dp_q,        dp_d;
  logic                    ack_q,       ack_d;
  logic [4*NUM_DIGITS-1:0] active_q,    active_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q,    shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q,   pending_d;

  logic                    cnt_clear;
  logic                    cnt_load;
  logic [CNT_W-1:0]        cnt_load_val;
  logic                    cnt_dec;
  logic                    cnt_zero;

  logic                    commit;
  logic [4*NUM_DIGITS-1:0] src_data;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic [NUM_DIGITS-1:0]   sel_anode;

  seg_tick_counter #(
    .WIDTH (CNT_W)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // A commit lands on the very edge digit 0 lights, so that digit must already
  // be fed from the shadow copy rather than the stale active copy.
  always_comb begin
    commit     = enable && (state_q == BLANK) && cnt_zero &&
                 (idx_q == '0) && pending_q;
    src_data   = commit ? shadow_q    : active_q;
    src_dp     = commit ? shadow_dp_q : active_dp_q;
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_anode  = C_ANODE_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nibble   = src_data[4*k +: 4];
        sel_dp       = src_dp[k];
        sel_anode[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    anode_d      = anode_q;
    nibble_d     = nibble_q;
    dp_d         = dp_q;
    ack_d        = 1'b0;
    active_d     = active_q;
    active_dp_d  = active_dp_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (commit) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pending_d   = 1'b0;
      ack_d       = 1'b1;
    end

    // Evaluated after the commit so a coincident load re-arms pending.
    if (load) begin
      shadow_d    = data_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    if (!enable) begin
      state_d   = IDLE;
      idx_d     = '0;
      anode_d   = C_ANODE_OFF;
      dp_d      = 1'b1;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = BLANK;
          idx_d        = '0;
          anode_d      = C_ANODE_OFF;
          dp_d         = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = C_BLANK_LOAD;
        end
        BLANK: begin
          if (cnt_zero) begin
            state_d      = SHOW;
            anode_d      = sel_anode;
            nibble_d     = sel_nibble;
            dp_d         = ~sel_dp;
            cnt_load     = 1'b1;
            cnt_load_val = C_SHOW_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        SHOW: begin
          if (cnt_zero) begin
            state_d      = BLANK;
            anode_d      = C_ANODE_OFF;
            dp_d         = 1'b1;
            idx_d        = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = C_BLANK_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          idx_d     = '0;
          anode_d   = C_ANODE_OFF;
          dp_d      = 1'b1;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      anode_q     <= C_ANODE_OFF;
      nibble_q    <= '0;
      dp_q        <= 1'b1;
      ack_q       <= 1'b0;
      active_q    <= '0;
      active_dp_q <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      anode_q     <= anode_d;
      nibble_q    <= nibble_d;
      dp_q        <= dp_d;
      ack_q       <= ack_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
    end
  end

  assign load_ack     = ack_q;
  assign digit_nibble = nibble_q;
  assign anode_n      = anode_q;
  assign dp_n         = dp_q;
  assign digit_idx    = idx_q;

endmodule

`default_nettype wire
